// File: rtl/instruction_fetch.sv
// Program sequencer: holds the PC, fetches from a synchronous program ROM and
// latches the instruction register, presenting opcode/operand to the decoder.
// Each instruction walks FETCH -> LOAD -> EXEC and leaves EXEC on exec_done.
module instruction_fetch #(
  parameter int unsigned OPCODE_BITS = 4,
  parameter int unsigned ADDR_BITS   = 4,
  localparam int unsigned INSTR_BITS = OPCODE_BITS + ADDR_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [ADDR_BITS-1:0]   rom_addr,
  input  logic [INSTR_BITS-1:0]  rom_data,
  input  logic                   jump,
  input  logic                   jump_cond,
  input  logic                   zero_flag,
  input  logic                   exec_done,
  output logic [OPCODE_BITS-1:0] opcode,
  output logic [ADDR_BITS-1:0]   operand,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc
);

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic [INSTR_BITS-1:0] ir_q, ir_d;
  logic                  take_branch;

  assign take_branch = jump || (jump_cond && zero_flag);

  // Next-state, IR capture and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StFetch: state_d = StLoad;
      StLoad: begin
        ir_d    = rom_data;
        state_d = StExec;
      end
      StExec: begin
        if (exec_done) begin
          state_d = StFetch;
          // PC wraps naturally at 2**ADDR_BITS.
          pc_d    = take_branch ? ir_q[ADDR_BITS-1:0] : pc_q + ADDR_BITS'(1);
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers; reset wins over enable, enable=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else if (enable) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign opcode      = ir_q[INSTR_BITS-1 -: OPCODE_BITS];
  assign operand     = ir_q[ADDR_BITS-1:0];
  assign instr_valid = (state_q == StExec);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a sync ROM model, a transaction-level program
// model that queues each expected instruction, and a monitor that checks them.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst, enable, jump, jump_cond, zero_flag, exec_done;
  logic [7:0] rom_data;
  logic [3:0] rom_addr, opcode, operand, pc;
  logic       instr_valid;

  always #5 clk = ~clk;

  instruction_fetch #(.OPCODE_BITS(4), .ADDR_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .jump       (jump),
    .jump_cond  (jump_cond),
    .zero_flag  (zero_flag),
    .exec_done  (exec_done),
    .opcode     (opcode),
    .operand    (operand),
    .instr_valid(instr_valid),
    .pc         (pc)
  );

  // Synchronous program ROM: data valid one cycle after the address.
  logic [7:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ir;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_pc = '0;
  int         m_phase = 0; // enabled edges into the current instruction (0..2)
  bit         started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the program model.
  task automatic step(input bit r, input bit en, input bit done, input bit j, input bit jc,
                      input bit z);
    exp_t e;
    rst = r; enable = en; exec_done = done; jump = j; jump_cond = jc; zero_flag = z;
    @(posedge clk);
    if (r) begin
      m_pc    = '0;
      m_phase = 0;
    end else if (en) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
        e.pc = m_pc;
        e.ir = rom[m_pc];
        exp_q.push_back(e);
      end else if (done) begin
        if (j || (jc && z)) m_pc = rom[m_pc][3:0];
        else m_pc = m_pc + 4'd1;
        m_phase = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One full instruction: random noise on ignored inputs, optional LOAD stall.
  task automatic run_instr(input int waits, input int stall, input bit j, input bit jc,
                           input bit z);
    step(1'b0, 1'b1, rb(), rb(), rb(), rb());
    repeat (stall) step(1'b0, 1'b0, rb(), rb(), rb(), rb());
    step(1'b0, 1'b1, rb(), rb(), rb(), rb());
    repeat (waits) step(1'b0, 1'b1, 1'b0, rb(), rb(), rb());
    step(1'b0, 1'b1, 1'b1, j, jc, z);
  endtask

  // Monitor: pops one expected instruction per EXEC entry, then checks stability.
  initial begin
    exp_t cur;
    bit   prev_valid;
    cur        = '0;
    prev_valid = 1'b0;
    wait (started);
    forever begin
      @(negedge clk);
      check("rom_addr_eq_pc", rom_addr, pc);
      if (instr_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_exec", 32'(instr_valid), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("exec_pc", pc, cur.pc);
          check("exec_opcode", opcode, cur.ir[7:4]);
          check("exec_operand", operand, cur.ir[3:0]);
        end
      end else if (instr_valid === 1'b1) begin
        check("hold_pc", pc, cur.pc);
        check("hold_opcode", opcode, cur.ir[7:4]);
        check("hold_operand", operand, cur.ir[3:0]);
      end
      prev_valid = (instr_valid === 1'b1);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h13;
    rom[1]  = 8'h2A;
    rom[2]  = 8'hF9; // jump to 9
    rom[9]  = 8'h5C; // jump_cond, zero clear -> fall through
    rom[10] = 8'h6D; // jump_cond, zero set -> 13
    rom[13] = 8'h8F; // jump + jump_cond -> 15
    rom[15] = 8'h94; // plain, wraps PC to 0
    rst = 1'b1; enable = 1'b0; jump = 1'b0; jump_cond = 1'b0; zero_flag = 1'b0;
    exec_done = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_pc", pc, 32'd0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_opcode", opcode, 32'd0);
    check("reset_operand", operand, 32'd0);
    started = 1'b1;

    run_instr(0, 0, 1'b0, 1'b0, 1'b0); // pc 0 -> 1
    run_instr(0, 0, 1'b0, 1'b0, 1'b0); // pc 1 -> 2
    run_instr(0, 0, 1'b1, 1'b0, 1'b0); // pc 2 -> 9
    run_instr(0, 0, 1'b0, 1'b1, 1'b0); // pc 9 -> 10
    run_instr(1, 0, 1'b0, 1'b1, 1'b1); // pc 10 -> 13
    run_instr(0, 0, 1'b1, 1'b1, 1'b0); // pc 13 -> 15
    run_instr(5, 0, 1'b0, 1'b0, 1'b0); // pc 15 -> 0, long exec
    run_instr(0, 3, 1'b0, 1'b0, 1'b0); // pc 0 with LOAD frozen 3 cycles
    check("model_pc_after_directed", pc, 32'd1);

    // Reset while in EXEC abandons the instruction.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("midexec_reset_pc", pc, 32'd0);
    check("midexec_reset_valid", 32'(instr_valid), 32'd0);

    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0, rb(), rb(), rb());
    end

    // Drain the last instruction so every queued expectation gets observed.
    for (int n = 0; n < 8 && m_phase != 0; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drained_phase", 32'(m_phase), 32'd0);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("final_pc", pc, 32'(m_pc));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
